mc_ctrl: RTL and testbench



---
 rtl/mc_pkg.sv | 101 ++++++++++
 rtl/mc_decode.sv | 31 +++
 rtl/mc_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle control unit: state codes, opcode/funct
// constants, datapath select encodings and the ALU setting helper.
package mc_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FN_W    = 6;
    localparam int unsigned SEL_W   = 2;

    // GRF index written by jal (selected by grf_addr = GRF_ADDR_RA)
    localparam int unsigned RA_REG  = 31;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        OPC_RTYPE_ALU,
        OPC_ORI,
        OPC_LUI,
        OPC_LW,
        OPC_SW,
        OPC_BEQ,
        OPC_JAL,
        OPC_JR,
        OPC_ILLEGAL
    } op_class_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [FN_W-1:0] FN_ADDU  = 6'b100001;
    localparam logic [FN_W-1:0] FN_SUBU  = 6'b100011;
    localparam logic [FN_W-1:0] FN_JR    = 6'b001000;

    localparam logic [SEL_W-1:0] PC_SEL_PC4    = 2'd0;
    localparam logic [SEL_W-1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [SEL_W-1:0] PC_SEL_JUMP   = 2'd2;
    localparam logic [SEL_W-1:0] PC_SEL_RS     = 2'd3;

    localparam logic [SEL_W-1:0] GRF_ADDR_RT   = 2'd0;
    localparam logic [SEL_W-1:0] GRF_ADDR_RD   = 2'd1;
    localparam logic [SEL_W-1:0] GRF_ADDR_RA   = 2'd2;

    localparam logic [SEL_W-1:0] GRF_DATA_ALU  = 2'd0;
    localparam logic [SEL_W-1:0] GRF_DATA_DM   = 2'd1;
    localparam logic [SEL_W-1:0] GRF_DATA_PC   = 2'd2;

    localparam logic [SEL_W-1:0] ALU_ADD       = 2'd0;
    localparam logic [SEL_W-1:0] ALU_SUB       = 2'd1;
    localparam logic [SEL_W-1:0] ALU_OR        = 2'd2;
    localparam logic [SEL_W-1:0] ALU_LUI       = 2'd3;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

    // ALU/EXT configuration for one op-class; held from EXEC through WB
    typedef struct packed {
        logic [SEL_W-1:0] alu_op;
        logic             alu_src;
        logic             ext_op;
    } alu_cfg_t;

    function automatic alu_cfg_t alu_cfg(input op_class_t cls, input logic [FN_W-1:0] funct);
        alu_cfg_t cfg;
        cfg = '0;
        case (cls)
            OPC_RTYPE_ALU: cfg.alu_op = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
            OPC_ORI: begin
                cfg.alu_op  = ALU_OR;
                cfg.alu_src = 1'b1;
                cfg.ext_op  = EXT_ZERO;
            end
            OPC_LUI: begin
                cfg.alu_op  = ALU_LUI;
                cfg.alu_src = 1'b1;
            end
            OPC_LW, OPC_SW: begin
                cfg.alu_op  = ALU_ADD;
                cfg.alu_src = 1'b1;
                cfg.ext_op  = EXT_SIGN;
            end
            OPC_BEQ: begin
                cfg.alu_op  = ALU_SUB;
                cfg.ext_op  = EXT_SIGN;
            end
            default: cfg = '0;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Opcode/funct to op-class decoder; anything unrecognised is ILLEGAL.
module mc_decode
    import mc_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] funct,
    output op_class_t       op_class
);

    // Classify the latched instruction
    always_comb begin
        op_class = OPC_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU: op_class = OPC_RTYPE_ALU;
                    FN_JR:            op_class = OPC_JR;
                    default:          op_class = OPC_ILLEGAL;
                endcase
            end
            OP_ORI:  op_class = OPC_ORI;
            OP_LUI:  op_class = OPC_LUI;
            OP_LW:   op_class = OPC_LW;
            OP_SW:   op_class = OPC_SW;
            OP_BEQ:  op_class = OPC_BEQ;
            OP_JAL:  op_class = OPC_JAL;
            default: op_class = OPC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer driving the
// shared datapath enables and selects. Outputs are decoded combinationally
// from the state register, the IR fields and the ALU zero flag.
// Optional: define MC_PERF_CNT_EN to add cycle_cnt/instr_cnt counters.
module mc_ctrl
    import mc_pkg::*;
`ifdef MC_PERF_CNT_EN
#(
    parameter int unsigned CNT_W = 32
)
`endif
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FN_W-1:0]    funct,
    input  logic               zero,
    output logic               ir_we,
    output logic               pc_we,
    output logic [SEL_W-1:0]   pc_sel,
    output logic               grf_we,
    output logic [SEL_W-1:0]   grf_addr,
    output logic [SEL_W-1:0]   grf_data,
    output logic [SEL_W-1:0]   alu_op,
    output logic               alu_src,
    output logic               ext_op,
    output logic               dm_we,
    output logic [STATE_W-1:0] state,
    output logic               instr_done
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instr_cnt
`endif
);

    state_t    state_q;
    state_t    state_d;
    op_class_t op_class;
    alu_cfg_t  cfg;

    mc_decode u_decode (
        .opcode   (opcode),
        .funct    (funct),
        .op_class (op_class)
    );

    assign cfg   = alu_cfg(op_class, funct);
    assign state = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-phase datapath control; reset forces all outputs low
    always_comb begin
        state_d    = ST_FETCH;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PC_SEL_PC4;
        grf_we     = 1'b0;
        grf_addr   = GRF_ADDR_RT;
        grf_data   = GRF_DATA_ALU;
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        ext_op     = EXT_ZERO;
        dm_we      = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            ST_FETCH: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = PC_SEL_PC4;
                state_d = ST_DECODE;
            end

            ST_DECODE: begin
                case (op_class)
                    OPC_JAL: begin
                        grf_we     = 1'b1;
                        grf_addr   = GRF_ADDR_RA;
                        grf_data   = GRF_DATA_PC;
                        pc_we      = 1'b1;
                        pc_sel     = PC_SEL_JUMP;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    OPC_JR: begin
                        pc_we      = 1'b1;
                        pc_sel     = PC_SEL_RS;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    OPC_ILLEGAL: begin
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    default: state_d = ST_EXEC;
                endcase
            end

            ST_EXEC: begin
                alu_op  = cfg.alu_op;
                alu_src = cfg.alu_src;
                ext_op  = cfg.ext_op;
                case (op_class)
                    OPC_BEQ: begin
                        pc_sel     = PC_SEL_BRANCH;
                        pc_we      = zero;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    OPC_LW, OPC_SW: state_d = ST_MEM;
                    default:        state_d = ST_WB;
                endcase
            end

            ST_MEM: begin
                // Hold the address computation stable across the memory access
                alu_op  = cfg.alu_op;
                alu_src = cfg.alu_src;
                ext_op  = cfg.ext_op;
                case (op_class)
                    OPC_SW: begin
                        dm_we      = 1'b1;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    OPC_LW:  state_d = ST_WB;
                    default: state_d = ST_FETCH;
                endcase
            end

            ST_WB: begin
                alu_op     = cfg.alu_op;
                alu_src    = cfg.alu_src;
                ext_op     = cfg.ext_op;
                grf_we     = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
                case (op_class)
                    OPC_RTYPE_ALU: begin
                        grf_addr = GRF_ADDR_RD;
                        grf_data = GRF_DATA_ALU;
                    end
                    OPC_LW: begin
                        grf_addr = GRF_ADDR_RT;
                        grf_data = GRF_DATA_DM;
                    end
                    default: begin
                        grf_addr = GRF_ADDR_RT;
                        grf_data = GRF_DATA_ALU;
                    end
                endcase
            end

            default: state_d = ST_FETCH;
        endcase

        // No partial writes while reset is asserted
        if (reset) begin
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            pc_sel     = PC_SEL_PC4;
            grf_we     = 1'b0;
            grf_addr   = GRF_ADDR_RT;
            grf_data   = GRF_DATA_ALU;
            alu_op     = ALU_ADD;
            alu_src    = 1'b0;
            ext_op     = EXT_ZERO;
            dm_we      = 1'b0;
            instr_done = 1'b0;
        end
    end

`ifdef MC_PERF_CNT_EN
    // Free-running cycle and retired-instruction counters, wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (instr_done) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle expected control vectors are
// queued per instruction and compared against the DUT outputs each cycle.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       ir_we, pc_we, grf_we, alu_src, ext_op, dm_we, instr_done;
    logic [1:0] pc_sel, grf_addr, grf_data, alu_op;
    logic [2:0] state;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .grf_we     (grf_we),
        .grf_addr   (grf_addr),
        .grf_data   (grf_data),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .ext_op     (ext_op),
        .dm_we      (dm_we),
        .state      (state),
        .instr_done (instr_done)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    // {state, ir_we, pc_we, pc_sel, grf_we, grf_addr, grf_data, alu_op, alu_src, ext_op, dm_we, instr_done}
    typedef logic [17:0] vec_t;

    vec_t obs;
    assign obs = {state, ir_we, pc_we, pc_sel, grf_we, grf_addr, grf_data,
                  alu_op, alu_src, ext_op, dm_we, instr_done};

    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    function automatic vec_t v(input logic [2:0] st, input logic irw, input logic pcw,
                               input logic [1:0] pcs, input logic gw, input logic [1:0] ga,
                               input logic [1:0] gd, input logic [1:0] ao, input logic as,
                               input logic eo, input logic dw, input logic dn);
        return {st, irw, pcw, pcs, gw, ga, gd, ao, as, eo, dw, dn};
    endfunction

    task automatic check_vec(input string tag, input vec_t e);
        n_checks++;
        assert (obs === e) else begin
            n_fails++;
            $error("FAIL %s: observed %b required %b", tag, obs, e);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fails++;
            $error("FAIL %s: observed %0d required %0d", tag, o, e);
        end
    endtask

    // Expected per-cycle control vectors for one instruction
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        vec_t fetch_v, dec_v, illegal_v;
        fetch_v   = v(3'd0, 1, 1, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0);
        dec_v     = v(3'd1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0);
        illegal_v = v(3'd1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1);
        exp_q.push_back(fetch_v);
        case (op)
            6'b000000: begin
                if (fn == 6'b100001) begin
                    exp_q.push_back(dec_v);
                    exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0));
                    exp_q.push_back(v(3'd4, 0, 0, 2'd0, 1, 2'd1, 2'd0, 2'd0, 0, 0, 0, 1));
                end else if (fn == 6'b100011) begin
                    exp_q.push_back(dec_v);
                    exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0));
                    exp_q.push_back(v(3'd4, 0, 0, 2'd0, 1, 2'd1, 2'd0, 2'd1, 0, 0, 0, 1));
                end else if (fn == 6'b001000) begin
                    exp_q.push_back(v(3'd1, 0, 1, 2'd3, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1));
                end else begin
                    exp_q.push_back(illegal_v);
                end
            end
            6'b001101: begin
                exp_q.push_back(dec_v);
                exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd2, 1, 0, 0, 0));
                exp_q.push_back(v(3'd4, 0, 0, 2'd0, 1, 2'd0, 2'd0, 2'd2, 1, 0, 0, 1));
            end
            6'b001111: begin
                exp_q.push_back(dec_v);
                exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd3, 1, 0, 0, 0));
                exp_q.push_back(v(3'd4, 0, 0, 2'd0, 1, 2'd0, 2'd0, 2'd3, 1, 0, 0, 1));
            end
            6'b100011: begin
                exp_q.push_back(dec_v);
                exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 1, 1, 0, 0));
                exp_q.push_back(v(3'd3, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 1, 1, 0, 0));
                exp_q.push_back(v(3'd4, 0, 0, 2'd0, 1, 2'd0, 2'd1, 2'd0, 1, 1, 0, 1));
            end
            6'b101011: begin
                exp_q.push_back(dec_v);
                exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 1, 1, 0, 0));
                exp_q.push_back(v(3'd3, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 1, 1, 1, 1));
            end
            6'b000100: begin
                exp_q.push_back(dec_v);
                exp_q.push_back(v(3'd2, 0, z, 2'd1, 0, 2'd0, 2'd0, 2'd1, 0, 1, 0, 1));
            end
            6'b000011: begin
                exp_q.push_back(v(3'd1, 0, 1, 2'd2, 1, 2'd2, 2'd2, 2'd0, 0, 0, 0, 1));
            end
            default: exp_q.push_back(illegal_v);
        endcase
    endtask

    // Run one instruction from FETCH; called at a falling edge while in FETCH
    task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn, input logic z);
        vec_t e;
        int   step;
        opcode = op;
        funct  = fn;
        zero   = z;
        push_instr(op, fn, z);
        step = 0;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            check_vec($sformatf("%s[%0d]", name, step), e);
            step++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t zv;
        zv     = '0;
        reset  = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b000000;
        zero   = 1'b0;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_vec($sformatf("reset[%0d]", i), zv);
        end
        reset = 1'b0;

        run("ori",      6'b001101, 6'b000000, 1'b0);
        run("lw",       6'b100011, 6'b000000, 1'b0);
        run("sw",       6'b101011, 6'b000000, 1'b0);
        run("beq_z1",   6'b000100, 6'b000000, 1'b1);
        run("beq_z0",   6'b000100, 6'b000000, 1'b0);
        run("jal",      6'b000011, 6'b000000, 1'b0);
        run("illegal",  6'b111111, 6'b000000, 1'b0);
        run("addu",     6'b000000, 6'b100001, 1'b0);
        run("subu",     6'b000000, 6'b100011, 1'b1);
        run("jr",       6'b000000, 6'b001000, 1'b0);
        run("lui",      6'b001111, 6'b000000, 1'b0);
        run("sll_nop",  6'b000000, 6'b000000, 1'b0);
        run("r_add",    6'b000000, 6'b100000, 1'b0);

        // Reset during the MEM cycle of sw abandons the store
        opcode = 6'b101011;
        funct  = 6'b000000;
        zero   = 1'b0;
        push_instr(6'b101011, 6'b000000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            vec_t e;
            #1;
            e = exp_q.pop_front();
            check_vec($sformatf("sw_rst[%0d]", i), e);
            @(negedge clk);
        end
        exp_q.delete();
        reset = 1'b1;
        #1;
        check_vec("sw_rst_mem", v(3'd3, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        check_vec("sw_rst_after", zv);
        reset = 1'b0;

        run("ori_post", 6'b001101, 6'b000000, 1'b0);

`ifdef MC_PERF_CNT_EN
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_val("cycle_cnt_rst", cycle_cnt, 32'd0);
        check_val("instr_cnt_rst", instr_cnt, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            run($sformatf("perf_ori%0d", i), 6'b001101, 6'b000000, 1'b0);
        end
        #1;
        check_val("instr_cnt", instr_cnt, 32'd10);
        check_val("cycle_cnt", cycle_cnt, 32'd40);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
